// File: rtl/venta_pkg.sv
// Shared types and constants for the vending-machine sale path.
package venta_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    localparam logic [5:0] COIN1 = 6'd1;
    localparam logic [5:0] COIN5 = 6'd5;

    localparam logic [1:0] PROD_0    = 2'd0;
    localparam logic [1:0] PROD_1    = 2'd1;
    localparam logic [1:0] PROD_2    = 2'd2;
    localparam logic [1:0] PROD_NONE = 2'd3;

endpackage

// File: rtl/control_venta_selector_precio.sv
// Combinational product-code to price lookup; code 3 has no product.
module selector_precio
    import venta_pkg::*;
#(
    parameter logic [5:0] PRICE_0 = 6'd7,
    parameter logic [5:0] PRICE_1 = 6'd12,
    parameter logic [5:0] PRICE_2 = 6'd20
) (
    input  logic [1:0] sel,
    output logic [5:0] price,
    output logic       price_valid
);

    always_comb begin
        price       = '0;
        price_valid = 1'b1;
        case (sel)
            PROD_0:  price = PRICE_0;
            PROD_1:  price = PRICE_1;
            PROD_2:  price = PRICE_2;
            default: price_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_venta.sv
// Sale controller: owns the credit register, checks prices, dispenses and
// pays back change one coin per cycle. All outputs are registered.
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | no credit; waiting for a coin
// CREDIT   | credit > 0; accepts coins, selection or cancel
// DISPENSE | product released this cycle
// CHANGE   | one change coin ejected per cycle until credit is 0
module control_venta
    import venta_pkg::*;
#(
    parameter logic [5:0] PRICE_0    = 6'd7,
    parameter logic [5:0] PRICE_1    = 6'd12,
    parameter logic [5:0] PRICE_2    = 6'd20,
    parameter logic [5:0] MAX_CREDIT = 6'd40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_in,
    input  logic [5:0] dinero_total,
    input  logic       sel_valid,
    input  logic [1:0] sel,
    input  logic       cancel,
    output logic [5:0] dinero_actual,
    output logic       dispense,
    output logic [1:0] producto,
    output logic       change5,
    output logic       change1,
    output logic       coin_reject,
    output logic       insufficient,
    output logic       busy
);

    state_t     state_q, state_n;
    logic [5:0] credit_n;
    logic [1:0] producto_n;
    logic       dispense_n, change5_n, change1_n, reject_n, insuff_n, busy_n;
    logic       do_change;
    logic [5:0] change_base;
    logic [5:0] price;
    logic       price_valid;

    selector_precio #(
        .PRICE_0 (PRICE_0),
        .PRICE_1 (PRICE_1),
        .PRICE_2 (PRICE_2)
    ) u_selector (
        .sel         (sel),
        .price       (price),
        .price_valid (price_valid)
    );

    always_comb begin
        state_n     = state_q;
        credit_n    = dinero_actual;
        producto_n  = producto;
        dispense_n  = 1'b0;
        change5_n   = 1'b0;
        change1_n   = 1'b0;
        reject_n    = 1'b0;
        insuff_n    = 1'b0;
        do_change   = 1'b0;
        change_base = dinero_actual;

        case (state_q)
            IDLE, CREDIT: begin
                if (cancel && state_q == CREDIT) begin
                    state_n   = CHANGE;
                    do_change = 1'b1;
                end else if (sel_valid && state_q == CREDIT) begin
                    if (!price_valid || dinero_actual < price) begin
                        insuff_n = 1'b1;
                    end else begin
                        credit_n   = dinero_actual - price;
                        producto_n = sel;
                        dispense_n = 1'b1;
                        state_n    = DISPENSE;
                    end
                end
                // A coin colliding with cancel/selection is never credited.
                if (coin_in) begin
                    if (cancel || sel_valid) begin
                        reject_n = 1'b1;
                    end else if (dinero_total <= MAX_CREDIT && dinero_total > dinero_actual) begin
                        credit_n = dinero_total;
                        state_n  = CREDIT;
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                reject_n = coin_in;
                if (dinero_actual != '0) begin
                    state_n   = CHANGE;
                    do_change = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            CHANGE: begin
                reject_n = coin_in;
                if (dinero_actual != '0) begin
                    do_change = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (do_change) begin
            if (change_base >= COIN5) begin
                change5_n = 1'b1;
                credit_n  = change_base - COIN5;
            end else begin
                change1_n = 1'b1;
                credit_n  = change_base - COIN1;
            end
        end

        busy_n = (state_n == DISPENSE) || (state_n == CHANGE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            dinero_actual <= '0;
            producto      <= '0;
            dispense      <= 1'b0;
            change5       <= 1'b0;
            change1       <= 1'b0;
            coin_reject   <= 1'b0;
            insufficient  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_n;
            dinero_actual <= credit_n;
            producto      <= producto_n;
            dispense      <= dispense_n;
            change5       <= change5_n;
            change1       <= change1_n;
            coin_reject   <= reject_n;
            insufficient  <= insuff_n;
            busy          <= busy_n;
        end
    end

endmodule

// File: tb/tb_control_venta.sv
// Scoreboard bench for control_venta: stimulus queues per-cycle expectations,
// a monitor pops and compares them one time unit after each rising edge.
module tb_control_venta;

    logic       clk;
    logic       rst;
    logic       coin_in;
    logic [5:0] dinero_total;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic [5:0] dinero_actual;
    logic       dispense;
    logic [1:0] producto;
    logic       change5;
    logic       change1;
    logic       coin_reject;
    logic       insufficient;
    logic       busy;

    control_venta dut (
        .clk           (clk),
        .rst           (rst),
        .coin_in       (coin_in),
        .dinero_total  (dinero_total),
        .sel_valid     (sel_valid),
        .sel           (sel),
        .cancel        (cancel),
        .dinero_actual (dinero_actual),
        .dispense      (dispense),
        .producto      (producto),
        .change5       (change5),
        .change1       (change1),
        .coin_reject   (coin_reject),
        .insufficient  (insufficient),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [13:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // {dinero_actual, dispense, producto, change5, change1, coin_reject, insufficient, busy}
    function automatic logic [13:0] mk(input logic [5:0] da, input logic disp, input logic [1:0] prod,
                                       input logic c5, input logic c1, input logic rej,
                                       input logic ins, input logic bsy);
        return {da, disp, prod, c5, c1, rej, ins, bsy};
    endfunction

    task automatic cyc(input logic r, input logic ci, input logic [5:0] dt, input logic sv,
                       input logic [1:0] s, input logic can, input logic [13:0] e, input string nm);
        @(negedge clk);
        rst          = r;
        coin_in      = ci;
        dinero_total = dt;
        sel_valid    = sv;
        sel          = s;
        cancel       = can;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
    endtask

    task automatic idle(input logic [13:0] e, input string nm);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, e, nm);
    endtask

    task automatic coin(input logic [5:0] dt, input logic [13:0] e, input string nm);
        cyc(1'b0, 1'b1, dt, 1'b0, 2'd0, 1'b0, e, nm);
    endtask

    initial begin : monitor
        logic [13:0] e;
        logic [13:0] got;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {dinero_actual, dispense, producto, change5, change1,
                       coin_reject, insufficient, busy};
                n_checks++;
                if (got !== e) begin
                    n_errors++;
                    $display("FAIL %s: got da=%0d disp=%b prod=%0d c5=%b c1=%b rej=%b ins=%b busy=%b, expected da=%0d disp=%b prod=%0d c5=%b c1=%b rej=%b ins=%b busy=%b",
                             nm, got[13:8], got[7], got[6:5], got[4], got[3], got[2], got[1], got[0],
                             e[13:8], e[7], e[6:5], e[4], e[3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin : stimulus
        int drain;
        rst = 1'b1; coin_in = 1'b0; dinero_total = '0;
        sel_valid = 1'b0; sel = '0; cancel = 1'b0;

        cyc(1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0), "reset0");
        cyc(1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0), "reset1");

        // Coins 5, 10, 11 then product 0 (price 7) -> 4 colones in 1-colon coins
        coin(6'd5,  mk(5,  0, 0, 0, 0, 0, 0, 0), "coin5");
        coin(6'd10, mk(10, 0, 0, 0, 0, 0, 0, 0), "coin10");
        coin(6'd11, mk(11, 0, 0, 0, 0, 0, 0, 0), "coin11");
        cyc(0, 0, 0, 1, 2'd0, 0, mk(4, 1, 0, 0, 0, 0, 0, 1), "sel0_dispense");
        idle(mk(3, 0, 0, 0, 1, 0, 0, 1), "sel0_chg1_a");
        idle(mk(2, 0, 0, 0, 1, 0, 0, 1), "sel0_chg1_b");
        idle(mk(1, 0, 0, 0, 1, 0, 0, 1), "sel0_chg1_c");
        idle(mk(0, 0, 0, 0, 1, 0, 0, 1), "sel0_chg1_d");
        idle(mk(0, 0, 0, 0, 0, 0, 0, 0), "sel0_idle");

        // Insufficient credit and invalid code
        coin(6'd5, mk(5, 0, 0, 0, 0, 0, 0, 0), "coin5_b");
        cyc(0, 0, 0, 1, 2'd1, 0, mk(5, 0, 0, 0, 0, 0, 1, 0), "insuff_sel1");
        cyc(0, 0, 0, 1, 2'd3, 0, mk(5, 0, 0, 0, 0, 0, 1, 0), "insuff_sel3");

        // Over-limit coin, then coin during DISPENSE
        coin(6'd25, mk(25, 0, 0, 0, 0, 0, 0, 0), "coin25");
        coin(6'd38, mk(38, 0, 0, 0, 0, 0, 0, 0), "coin38");
        coin(6'd43, mk(38, 0, 0, 0, 0, 1, 0, 0), "reject_over_max");
        cyc(0, 0, 0, 1, 2'd2, 0, mk(18, 1, 2, 0, 0, 0, 0, 1), "sel2_dispense");
        coin(6'd23, mk(13, 0, 2, 1, 0, 1, 0, 1), "coin_in_dispense");
        idle(mk(8, 0, 2, 1, 0, 0, 0, 1), "sel2_chg5_b");
        idle(mk(3, 0, 2, 1, 0, 0, 0, 1), "sel2_chg5_c");
        idle(mk(2, 0, 2, 0, 1, 0, 0, 1), "sel2_chg1_a");
        idle(mk(1, 0, 2, 0, 1, 0, 0, 1), "sel2_chg1_b");
        idle(mk(0, 0, 2, 0, 1, 0, 0, 1), "sel2_chg1_c");
        idle(mk(0, 0, 2, 0, 0, 0, 0, 0), "sel2_idle");

        // Cancel at 11 -> 5, 5, 1
        coin(6'd11, mk(11, 0, 2, 0, 0, 0, 0, 0), "coin11_c");
        cyc(0, 0, 0, 0, 0, 1, mk(6, 0, 2, 1, 0, 0, 0, 1), "cancel_chg5_a");
        idle(mk(1, 0, 2, 1, 0, 0, 0, 1), "cancel_chg5_b");
        idle(mk(0, 0, 2, 0, 1, 0, 0, 1), "cancel_chg1");
        idle(mk(0, 0, 2, 0, 0, 0, 0, 0), "cancel_idle");

        // Exact payment with a colliding coin
        coin(6'd12, mk(12, 0, 2, 0, 0, 0, 0, 0), "coin12");
        cyc(0, 1, 6'd17, 1, 2'd1, 0, mk(0, 1, 1, 0, 0, 1, 0, 1), "exact_sel1_coin");
        idle(mk(0, 0, 1, 0, 0, 0, 0, 0), "exact_idle");

        // Selection and cancel ignored in IDLE
        cyc(0, 0, 0, 0, 0, 1, mk(0, 0, 1, 0, 0, 0, 0, 0), "cancel_in_idle");
        cyc(0, 0, 0, 1, 2'd0, 0, mk(0, 0, 1, 0, 0, 0, 0, 0), "sel_in_idle");

        // Wrap rejection, MAX_CREDIT boundary, then full payback
        coin(6'd6,  mk(6,  0, 1, 0, 0, 0, 0, 0), "coin6");
        coin(6'd3,  mk(6,  0, 1, 0, 0, 1, 0, 0), "reject_wrap");
        coin(6'd40, mk(40, 0, 1, 0, 0, 0, 0, 0), "coin_at_max");
        cyc(0, 0, 0, 0, 0, 1, mk(35, 0, 1, 1, 0, 0, 0, 1), "max_cancel");
        for (int i = 1; i < 8; i++)
            idle(mk(6'(35 - 5 * i), 0, 1, 1, 0, 0, 0, 1), "max_chg5");
        idle(mk(0, 0, 1, 0, 0, 0, 0, 0), "max_idle");

        // Reset during CHANGE at credit 6
        coin(6'd11, mk(11, 0, 1, 0, 0, 0, 0, 0), "coin11_r");
        cyc(0, 0, 0, 0, 0, 1, mk(6, 0, 1, 1, 0, 0, 0, 1), "rst_pre_chg5");
        cyc(1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0), "rst_mid_change");
        idle(mk(0, 0, 0, 0, 0, 0, 0, 0), "after_rst_a");
        idle(mk(0, 0, 0, 0, 0, 0, 0, 0), "after_rst_b");

        drain = 0;
        while (exp_q.size() != 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
